// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between instruction fetch (IF) and
// data access (MEM). Grants one requester at a time, runs a ready-handshake
// access, returns a one-cycle ack and aborts accesses the RAM never completes.
// Optional feature macro: ARB_RR_EN selects round-robin arbitration on
// contention; without it MEM has fixed priority over IF.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic [DW-1:0] o_if_rdata,
  output logic          o_if_ack,
  input  logic          i_mem_req,
  input  logic          i_mem_we,
  input  logic [AW-1:0] i_mem_addr,
  input  logic [DW-1:0] i_mem_wdata,
  output logic [DW-1:0] o_mem_rdata,
  output logic          o_mem_ack,
  output logic          o_stall_if,
  output logic          o_stall_mem,
  output logic          o_ram_en,
  output logic          o_ram_we,
  output logic [AW-1:0] o_ram_addr,
  output logic [DW-1:0] o_ram_wdata,
  input  logic [DW-1:0] i_ram_rdata,
  input  logic          i_ram_ready,
  output logic          o_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    BUSY_IF  = 2'd1,
    BUSY_MEM = 2'd2
  } state_t;

  // Last BUSY cycle that may still complete; reaching it without ready aborts.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t        state_reg, state_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic          ram_en_reg, ram_en_next;
  logic          ram_we_reg, ram_we_next;
  logic [AW-1:0] ram_addr_reg, ram_addr_next;
  logic [DW-1:0] ram_wdata_reg, ram_wdata_next;
  logic [DW-1:0] if_rdata_reg, if_rdata_next;
  logic [DW-1:0] mem_rdata_reg, mem_rdata_next;
  logic          if_ack_reg, if_ack_next;
  logic          mem_ack_reg, mem_ack_next;
  logic          err_reg, err_next;

  logic          if_elig, mem_elig, mem_wins, grant_mem, grant_if;

  // A port in its ack cycle is masked so a held request is not served twice.
  assign if_elig  = i_if_req  & ~if_ack_reg;
  assign mem_elig = i_mem_req & ~mem_ack_reg;

`ifdef ARB_RR_EN
  logic last_mem_reg, last_mem_next;

  assign mem_wins = ~last_mem_reg;

  // Remember which port was granted last; the other one wins the next tie.
  always_comb begin
    last_mem_next = last_mem_reg;
    if (grant_mem)
      last_mem_next = 1'b1;
    else if (grant_if)
      last_mem_next = 1'b0;
  end

  // Pointer register; out of reset MEM wins the first contention.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      last_mem_reg <= 1'b0;
    else
      last_mem_reg <= last_mem_next;
  end
`else
  // MEM carries the older instruction, so it always wins a tie.
  assign mem_wins = 1'b1;
`endif

  assign grant_mem = (state_reg == IDLE) & mem_elig & (~if_elig | mem_wins);
  assign grant_if  = (state_reg == IDLE) & if_elig & ~grant_mem;

  // Next-state and registered-output logic.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    ram_en_next    = ram_en_reg;
    ram_we_next    = ram_we_reg;
    ram_addr_next  = ram_addr_reg;
    ram_wdata_next = ram_wdata_reg;
    if_rdata_next  = if_rdata_reg;
    mem_rdata_next = mem_rdata_reg;
    if_ack_next    = 1'b0;
    mem_ack_next   = 1'b0;
    err_next       = 1'b0;

    case (state_reg)
      IDLE: begin
        // i_ram_ready is deliberately ignored here.
        if (grant_mem) begin
          state_next     = BUSY_MEM;
          cnt_next       = 8'd0;
          ram_en_next    = 1'b1;
          ram_we_next    = i_mem_we;
          ram_addr_next  = i_mem_addr;
          ram_wdata_next = i_mem_wdata;
        end else if (grant_if) begin
          state_next    = BUSY_IF;
          cnt_next      = 8'd0;
          ram_en_next   = 1'b1;
          ram_we_next   = 1'b0;
          ram_addr_next = i_if_addr;
        end
      end

      BUSY_IF, BUSY_MEM: begin
        if (i_ram_ready) begin
          // Normal completion; a write leaves the rdata output untouched.
          state_next  = IDLE;
          ram_en_next = 1'b0;
          if (state_reg == BUSY_MEM) begin
            mem_ack_next = 1'b1;
            if (!ram_we_reg)
              mem_rdata_next = i_ram_rdata;
          end else begin
            if_ack_next   = 1'b1;
            if_rdata_next = i_ram_rdata;
          end
        end else if (cnt_reg == CNT_LAST) begin
          // Watchdog abort: ack with error and zeroed data.
          state_next  = IDLE;
          ram_en_next = 1'b0;
          err_next    = 1'b1;
          if (state_reg == BUSY_MEM) begin
            mem_ack_next   = 1'b1;
            mem_rdata_next = '0;
          end else begin
            if_ack_next   = 1'b1;
            if_rdata_next = '0;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  // State, counter and output registers; reset aborts any access silently.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= 8'd0;
      ram_en_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
      if_rdata_reg  <= '0;
      mem_rdata_reg <= '0;
      if_ack_reg    <= 1'b0;
      mem_ack_reg   <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      ram_en_reg    <= ram_en_next;
      ram_we_reg    <= ram_we_next;
      ram_addr_reg  <= ram_addr_next;
      ram_wdata_reg <= ram_wdata_next;
      if_rdata_reg  <= if_rdata_next;
      mem_rdata_reg <= mem_rdata_next;
      if_ack_reg    <= if_ack_next;
      mem_ack_reg   <= mem_ack_next;
      err_reg       <= err_next;
    end
  end

  assign o_ram_en    = ram_en_reg;
  assign o_ram_we    = ram_we_reg;
  assign o_ram_addr  = ram_addr_reg;
  assign o_ram_wdata = ram_wdata_reg;
  assign o_if_rdata  = if_rdata_reg;
  assign o_mem_rdata = mem_rdata_reg;
  assign o_if_ack    = if_ack_reg;
  assign o_mem_ack   = mem_ack_reg;
  assign o_err       = err_reg;

  // Stalls freeze a stage from its request's first cycle up to its ack.
  assign o_stall_if  = i_if_req  & ~if_ack_reg;
  assign o_stall_mem = i_mem_req & ~mem_ack_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized requesters and RAM latency, all checked every
// cycle against an access-level reference model.
module tb_mem_port_arbiter;
  localparam int TO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_if_req;
  logic [31:0] i_if_addr;
  logic [31:0] o_if_rdata;
  logic        o_if_ack;
  logic        i_mem_req;
  logic        i_mem_we;
  logic [31:0] i_mem_addr;
  logic [31:0] i_mem_wdata;
  logic [31:0] o_mem_rdata;
  logic        o_mem_ack;
  logic        o_stall_if;
  logic        o_stall_mem;
  logic        o_ram_en;
  logic        o_ram_we;
  logic [31:0] o_ram_addr;
  logic [31:0] o_ram_wdata;
  logic [31:0] i_ram_rdata;
  logic        i_ram_ready;
  logic        o_err;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr),
    .o_if_rdata(o_if_rdata), .o_if_ack(o_if_ack),
    .i_mem_req(i_mem_req), .i_mem_we(i_mem_we), .i_mem_addr(i_mem_addr),
    .i_mem_wdata(i_mem_wdata), .o_mem_rdata(o_mem_rdata), .o_mem_ack(o_mem_ack),
    .o_stall_if(o_stall_if), .o_stall_mem(o_stall_mem),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(i_ram_rdata),
    .i_ram_ready(i_ram_ready), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  // RAM behind the port and the model's own view of its contents.
  logic [31:0] ram [32];
  logic [31:0] ref_mem [32];
  int en_count = 0;
  int ram_wait = 0;
  bit random_mode = 0;

  // Model: expected registered outputs for the current cycle plus the
  // record of the access in flight.
  logic        e_if_ack, e_mem_ack, e_err, e_ram_en, e_ram_we;
  logic [31:0] e_if_rdata, e_mem_rdata, e_ram_addr, e_ram_wdata;
  bit          a_mem;
  int          a_age;
  bit          last_mem;
  bit          prev_if_ack, prev_mem_ack;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%b expected=%b", name, cycle, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cycle, act, exp);
    end
  endtask

  task automatic model_reset();
    e_if_ack = 0; e_mem_ack = 0; e_err = 0; e_ram_en = 0; e_ram_we = 0;
    e_if_rdata = '0; e_mem_rdata = '0; e_ram_addr = '0; e_ram_wdata = '0;
    a_mem = 0; a_age = 0; last_mem = 0;
    prev_if_ack = 0; prev_mem_ack = 0;
  endtask

  // Advance the model by one clock using the inputs present this cycle.
  task automatic model_step();
    logic        n_if_ack, n_mem_ack, n_err, n_en, n_we;
    logic [31:0] n_if_rd, n_mem_rd, n_addr, n_wd;
    bit          if_el, mem_el, prefer_mem, pick_mem;
    n_if_ack = 0; n_mem_ack = 0; n_err = 0;
    n_en = e_ram_en; n_we = e_ram_we; n_addr = e_ram_addr; n_wd = e_ram_wdata;
    n_if_rd = e_if_rdata; n_mem_rd = e_mem_rdata;
    if (e_ram_en) begin
      if (i_ram_ready) begin
        n_en = 0;
        if (a_mem) n_mem_ack = 1; else n_if_ack = 1;
        if (e_ram_we) ref_mem[e_ram_addr[6:2]] = e_ram_wdata;
        else if (a_mem) n_mem_rd = ref_mem[e_ram_addr[6:2]];
        else n_if_rd = ref_mem[e_ram_addr[6:2]];
      end else if (a_age == TO) begin
        // TIMEOUT busy cycles without ready: ack+err TIMEOUT+1 after grant.
        n_en = 0; n_err = 1;
        if (a_mem) begin n_mem_ack = 1; n_mem_rd = '0; end
        else begin n_if_ack = 1; n_if_rd = '0; end
      end else begin
        a_age++;
      end
    end else begin
      if_el  = i_if_req && !e_if_ack;
      mem_el = i_mem_req && !e_mem_ack;
`ifdef ARB_RR_EN
      prefer_mem = !last_mem;
`else
      prefer_mem = 1;
`endif
      pick_mem = mem_el && (!if_el || prefer_mem);
      if (pick_mem) begin
        n_en = 1; n_we = i_mem_we; n_addr = i_mem_addr; n_wd = i_mem_wdata;
        a_mem = 1; a_age = 1; last_mem = 1;
      end else if (if_el) begin
        n_en = 1; n_we = 0; n_addr = i_if_addr;
        a_mem = 0; a_age = 1; last_mem = 0;
      end
    end
    e_if_ack = n_if_ack; e_mem_ack = n_mem_ack; e_err = n_err;
    e_ram_en = n_en; e_ram_we = n_we; e_ram_addr = n_addr; e_ram_wdata = n_wd;
    e_if_rdata = n_if_rd; e_mem_rdata = n_mem_rd;
  endtask

  // RAM responder: ready after ram_wait busy cycles, noise while idle.
  task automatic ram_drive();
    if (o_ram_en) begin
      if (en_count == ram_wait) begin
        i_ram_ready = 1;
        i_ram_rdata = ram[o_ram_addr[6:2]];
        if (o_ram_we) ram[o_ram_addr[6:2]] = o_ram_wdata;
      end else begin
        i_ram_ready = 0;
        i_ram_rdata = $urandom;
      end
      en_count++;
    end else begin
      en_count = 0;
      i_ram_ready = 1'($urandom_range(0, 1));
      i_ram_rdata = $urandom;
      if (random_mode) ram_wait = $urandom_range(0, 5);
    end
  endtask

  // One clock: respond, compare against the model, step the model.
  task automatic tick();
    ram_drive();
    #1;
    chk1("if_ack", o_if_ack, e_if_ack);
    chk1("mem_ack", o_mem_ack, e_mem_ack);
    chk1("err", o_err, e_err);
    chk1("ram_en", o_ram_en, e_ram_en);
    chk1("ram_we", o_ram_we, e_ram_we);
    chk32("ram_addr", o_ram_addr, e_ram_addr);
    chk32("ram_wdata", o_ram_wdata, e_ram_wdata);
    chk32("if_rdata", o_if_rdata, e_if_rdata);
    chk32("mem_rdata", o_mem_rdata, e_mem_rdata);
    chk1("stall_if", o_stall_if, i_if_req & ~e_if_ack);
    chk1("stall_mem", o_stall_mem, i_mem_req & ~e_mem_ack);
    if (o_if_ack)
      $display("txn cycle=%0d IF  addr=%h rdata=%h err=%b", cycle, o_ram_addr, o_if_rdata, o_err);
    if (o_mem_ack)
      $display("txn cycle=%0d MEM addr=%h we=%b rdata=%h err=%b", cycle, o_ram_addr, o_ram_we, o_mem_rdata, o_err);
    prev_if_ack  = e_if_ack;
    prev_mem_ack = e_mem_ack;
    model_step();
    @(posedge i_clk);
    #1;
    cycle++;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_ram_en"}, o_ram_en, 1'b0);
    chk1({tag, "_ram_we"}, o_ram_we, 1'b0);
    chk32({tag, "_ram_addr"}, o_ram_addr, 32'h0);
    chk32({tag, "_ram_wdata"}, o_ram_wdata, 32'h0);
    chk1({tag, "_if_ack"}, o_if_ack, 1'b0);
    chk1({tag, "_mem_ack"}, o_mem_ack, 1'b0);
    chk1({tag, "_err"}, o_err, 1'b0);
    chk32({tag, "_if_rdata"}, o_if_rdata, 32'h0);
    chk32({tag, "_mem_rdata"}, o_mem_rdata, 32'h0);
  endtask

  // Asynchronous reset asserted between clock edges.
  task automatic do_reset(input string tag);
    i_rst = 1;
    #1;
    chk_reset_vals(tag);
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst = 0;
    cycle++;
  endtask

  task automatic rand_req();
    if (i_if_req) begin
      if (prev_if_ack) begin
        if ($urandom_range(0, 1) == 1) begin
          i_if_addr = 32'($urandom_range(0, 31)) << 2;
        end else begin
          i_if_req = 0;
        end
      end
    end else if ($urandom_range(0, 2) == 0) begin
      i_if_req  = 1;
      i_if_addr = 32'($urandom_range(0, 31)) << 2;
    end
    if (i_mem_req) begin
      if (prev_mem_ack) begin
        if ($urandom_range(0, 1) == 1) begin
          i_mem_we    = 1'($urandom_range(0, 1));
          i_mem_addr  = 32'($urandom_range(0, 31)) << 2;
          i_mem_wdata = $urandom;
        end else begin
          i_mem_req = 0;
        end
      end
    end else if ($urandom_range(0, 2) == 0) begin
      i_mem_req   = 1;
      i_mem_we    = 1'($urandom_range(0, 1));
      i_mem_addr  = 32'($urandom_range(0, 31)) << 2;
      i_mem_wdata = $urandom;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog cycle=%0d got=no_finish expected=finish", cycle);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    i_rst = 1; i_if_req = 0; i_if_addr = '0; i_mem_req = 0; i_mem_we = 0;
    i_mem_addr = '0; i_mem_wdata = '0; i_ram_rdata = '0; i_ram_ready = 0;
    for (int i = 0; i < 32; i++) begin
      v = $urandom;
      ram[i] = v;
      ref_mem[i] = v;
    end
    ram[2] = 32'h11112222; ref_mem[2] = 32'h11112222;
    ram[4] = 32'h8C220004; ref_mem[4] = 32'h8C220004;
    ram[6] = 32'h33334444; ref_mem[6] = 32'h33334444;
    ram[8] = 32'h5A5A0020; ref_mem[8] = 32'h5A5A0020;

    repeat (2) @(posedge i_clk);
    #1;
    chk_reset_vals("por");
    model_reset();
    i_rst = 0;

    // Contention: MEM wins, IF granted in MEM's ack cycle.
    ram_wait = 0;
    i_mem_req = 1; i_mem_we = 0; i_mem_addr = 32'h08;
    i_if_req = 1; i_if_addr = 32'h18;
    tick();
    chk1("c_en", o_ram_en, 1'b1);
    chk32("c_addr_mem", o_ram_addr, 32'h08);
    tick();
    chk1("c_mem_ack", o_mem_ack, 1'b1);
    chk32("c_mem_rdata", o_mem_rdata, 32'h11112222);
    chk1("c_if_wait", o_if_ack, 1'b0);
    chk1("c_stall_if", o_stall_if, 1'b1);
    i_mem_req = 0;
    tick();
    chk1("c_en_if", o_ram_en, 1'b1);
    chk32("c_addr_if", o_ram_addr, 32'h18);
    tick();
    chk1("c_if_ack", o_if_ack, 1'b1);
    chk32("c_if_rdata", o_if_rdata, 32'h33334444);
    i_if_req = 0;
    tick(); tick();

    // IF read, ready on first busy cycle.
    i_if_req = 1; i_if_addr = 32'h10;
    #1;
    chk1("a_stall0", o_stall_if, 1'b1);
    tick();
    chk1("a_en1", o_ram_en, 1'b1);
    chk32("a_addr1", o_ram_addr, 32'h10);
    chk1("a_we1", o_ram_we, 1'b0);
    chk1("a_stall1", o_stall_if, 1'b1);
    tick();
    chk1("a_ack2", o_if_ack, 1'b1);
    chk32("a_rdata2", o_if_rdata, 32'h8C220004);
    chk1("a_en2", o_ram_en, 1'b0);
    chk1("a_stall2", o_stall_if, 1'b0);
    i_if_req = 0;
    tick(); tick();

    // MEM write with two wait cycles.
    ram_wait = 2;
    i_mem_req = 1; i_mem_we = 1; i_mem_addr = 32'h40; i_mem_wdata = 32'hDEADBEEF;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk1("b_en", o_ram_en, 1'b1);
      chk1("b_we", o_ram_we, 1'b1);
      chk32("b_addr", o_ram_addr, 32'h40);
      chk32("b_wdata", o_ram_wdata, 32'hDEADBEEF);
    end
    tick();
    chk1("b_ack4", o_mem_ack, 1'b1);
    chk32("b_rdata_kept", o_mem_rdata, 32'h11112222);
    chk1("b_err", o_err, 1'b0);
    i_mem_req = 0; i_mem_we = 0;
    tick(); tick();

    // Timeout: RAM never ready.
    ram_wait = 255;
    i_if_req = 1; i_if_addr = 32'h24;
    repeat (4) tick();
    chk1("d_en4", o_ram_en, 1'b1);
    chk1("d_noack4", o_if_ack, 1'b0);
    tick();
    chk1("d_ack5", o_if_ack, 1'b1);
    chk1("d_err5", o_err, 1'b1);
    chk32("d_rdata5", o_if_rdata, 32'h0);
    chk1("d_en5", o_ram_en, 1'b0);
    i_if_req = 0;
    tick(); tick();

    // Reset during BUSY_MEM; held request is re-granted afterwards.
    i_mem_req = 1; i_mem_we = 0; i_mem_addr = 32'h20;
    tick(); tick();
    do_reset("e_rst");
    ram_wait = 0;
    tick();
    chk1("e_regrant_en", o_ram_en, 1'b1);
    chk32("e_regrant_addr", o_ram_addr, 32'h20);
    tick();
    chk1("e_ack", o_mem_ack, 1'b1);
    chk1("e_err", o_err, 1'b0);
    chk32("e_rdata", o_mem_rdata, 32'h5A5A0020);
    i_mem_req = 0;
    tick();

    // Randomized traffic with random RAM latency, including timeouts.
    random_mode = 1;
    for (int n = 0; n < 3000; n++) begin
      rand_req();
      tick();
      if (n == 1500) do_reset("r_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port memory arbiter and sequencer for the five-stage pipeline. Instruction fetch (IF) and data access (MEM) share one memory port. The block grants the port to one requester at a time, runs a ready-handshake transaction with a variable-latency RAM, returns read data with a one-cycle ack, and drives per-stage stall signals that freeze the pipeline while an access is outstanding. A watchdog aborts any transaction the RAM never completes.

## Interface
- AW, 32, address width
- DW, 32, data width
- TIMEOUT, 255, max BUSY cycles before abort (1..255; counter is 8 bits)

- i_clk  in  1  clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_if_req  in  1  IF read request; held until o_if_ack
- i_if_addr  in  AW  IF read address
- o_if_rdata  out  DW  IF read data, valid with o_if_ack
- o_if_ack  out  1  one-cycle IF completion pulse
- i_mem_req  in  1  MEM request; held until o_mem_ack
- i_mem_we  in  1  1 = write, 0 = read
- i_mem_addr  in  AW  MEM address
- i_mem_wdata  in  DW  MEM write data
- o_mem_rdata  out  DW  MEM read data, valid with o_mem_ack
- o_mem_ack  out  1  one-cycle MEM completion pulse
- o_stall_if  out  1  i_if_req & ~o_if_ack
- o_stall_mem  out  1  i_mem_req & ~o_mem_ack
- o_ram_en  out  1  RAM command valid
- o_ram_we  out  1  RAM write strobe
- o_ram_addr  out  AW  RAM address
- o_ram_wdata  out  DW  RAM write data
- i_ram_rdata  in  DW  RAM read data, valid when i_ram_ready
- i_ram_ready  in  1  RAM completes the current command this cycle
- o_err  out  1  one-cycle pulse, sent together with the ack of a timed-out access

## Operation
- States: IDLE, BUSY_IF, BUSY_MEM.
- IDLE: a request is eligible if req=1 and that port's ack is 0 this cycle.
  - If exactly one request is eligible, go to its BUSY state.
  - If both are eligible, arbitration decides (see Configuration).
  - At this edge, latch addr, we and wdata into the o_ram_* registers and set o_ram_en=1. o_ram_we is forced to 0 for IF.
- BUSY_x with i_ram_ready=1:
  - o_ram_en→0.
  - o_x_ack→1 for one cycle.
  - For a read, o_x_rdata←i_ram_rdata. For a write, o_x_rdata holds its previous value.
  - Go to IDLE.
- BUSY_x with i_ram_ready=0: the timeout counter increments. When the counter reaches TIMEOUT-1 with no ready:
  - o_ram_en→0.
  - o_x_ack=1 and o_err=1 for one cycle; o_x_rdata←0.
  - Go to IDLE.
- The timeout counter clears on entry to BUSY.
- o_ram_addr, o_ram_we and o_ram_wdata are stable for the whole of BUSY.
- i_ram_ready is ignored in IDLE.
- Requesters drop req, or present a new request, in the cycle after the ack. The ack cycle masks that port's req, so one access is never served twice.
- Stall outputs are combinational and cover a request from its first cycle through the cycle before its ack.
- Reset (asynchronous):
  - State=IDLE.
  - o_ram_en, o_ram_we, both acks and o_err = 0.
  - o_ram_addr, o_ram_wdata, both rdata outputs and the counter = 0.
  - The RR pointer selects MEM.
- Reset mid-BUSY deasserts o_ram_en immediately. No ack is issued for the aborted access.

## Timing
- Request seen in IDLE at cycle 0 → o_ram_en=1 from cycle 1.
- i_ram_ready at cycle 1+W → ack at cycle 2+W.
- Minimum access (W=0): ack at cycle 2; 3 cycles per access including the IDLE cycle.
- Back-to-back: the second grant is issued from IDLE in the ack cycle. o_ram_en rises again the next cycle, so the RAM sees one idle cycle between commands.
- Timeout: with no ready, ack+err arrives TIMEOUT+1 cycles after the grant edge.
- All outputs except the stalls are registered.

## Configuration
- ARB_RR_EN defined: round-robin on contention. A 1-bit pointer holds the last-granted port, and the other port wins the next contention.
- ARB_RR_EN undefined: fixed priority on contention, MEM over IF, because MEM carries the older instruction. The pointer is not implemented.

## Test plan
- IF read, addr 0x00000010, ready on the first BUSY cycle, rdata 0x8C220004 → o_ram_en at cycle 1, o_if_ack and o_if_rdata=0x8C220004 at cycle 2, o_stall_if high for cycles 0–1.
- MEM write, addr 0x40, wdata 0xDEADBEEF, ready after 2 wait cycles → o_ram_we=1 with stable addr and data for 3 cycles, o_mem_ack at cycle 4, o_mem_rdata unchanged.
- IF and MEM both request at cycle 0, fixed priority → MEM granted first and acked at cycle 2, IF granted in that ack cycle and acked at cycle 4.
- ARB_RR_EN, both requesting continuously (new request each post-ack cycle) → grants alternate MEM, IF, MEM, IF; neither port waits more than one access.
- TIMEOUT=4, ready never asserted → o_ram_en low after 4 BUSY cycles, o_if_ack=1 with o_err=1 and o_if_rdata=0 at cycle 5, then IDLE.
- i_rst pulsed during BUSY_MEM → o_ram_en=0 immediately, no ack, state IDLE; the held request is re-granted after reset releases.
